// File: rtl/arb2_pkg.sv
// Shared constants for the two-channel round-robin arbiter.
package arb2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } arb_state_t;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  // Hold counter width; covers MAX_HOLD up to 255.
  localparam int unsigned HOLD_W = 8;

endpackage

// File: rtl/arb2_hold_cnt.sv
// Saturating hold counter: clears on grant entry, counts grant cycles,
// sticks at MAX_HOLD-1.
module arb2_hold_cnt
  import arb2_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic at_max
);

  localparam logic [HOLD_W-1:0] LIMIT = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign at_max = (count == LIMIT);

endmodule

// File: rtl/arb2_rr.sv
// Two-channel round-robin arbiter with hold-time preemption.
// Optional lock input (inhibits preemption) enabled by `define ARB2_LOCK_EN.
module arb2_rr
  import arb2_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
`ifdef ARB2_LOCK_EN
  input  logic lock,
`endif
  output logic gnt0,
  output logic gnt1,
  output logic sel,
  output logic busy
);

  arb_state_t state;
  arb_state_t next_state;
  logic       last;
  logic       at_max;
  logic       preempt_en;
  logic       cnt_clr;
  logic       cnt_en;

`ifdef ARB2_LOCK_EN
  assign preempt_en = ~lock;
`else
  assign preempt_en = 1'b1;
`endif

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
          next_state = (last == CH1) ? GNT0 : GNT1;
        end else if (req0) begin
          next_state = GNT0;
        end else if (req1) begin
          next_state = GNT1;
        end
      end
      GNT0: begin
        if (!req0) begin
          next_state = req1 ? GNT1 : IDLE;
        end else if (req1 && at_max && preempt_en) begin
          next_state = GNT1;
        end
      end
      GNT1: begin
        if (!req1) begin
          next_state = req0 ? GNT0 : IDLE;
        end else if (req0 && at_max && preempt_en) begin
          next_state = GNT0;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Counter controls are derived from the transition, so a direct
  // GNT0<->GNT1 hand-over also restarts the hold count.
  assign cnt_clr = (next_state != state) && (next_state != IDLE);
  assign cnt_en  = (state != IDLE) && (next_state == state);

  arb2_hold_cnt #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .at_max (at_max)
  );

  // Grants and sel are loaded from next_state so they are true flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      sel   <= CH0;
      last  <= CH1;
    end else begin
      state <= next_state;
      gnt0  <= (next_state == GNT0);
      gnt1  <= (next_state == GNT1);
      if (next_state == GNT0) begin
        sel <= CH0;
      end else if (next_state == GNT1) begin
        sel <= CH1;
      end
      if (cnt_clr) begin
        last <= (next_state == GNT1) ? CH1 : CH0;
      end
    end
  end

  assign busy = gnt0 | gnt1;

endmodule

// File: tb/tb_arb2_rr.sv
module tb_arb2_rr;

  localparam int unsigned MAX_HOLD = 4;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic req0   = 1'b0;
  logic req1   = 1'b0;
  logic lock_i = 1'b0;
  logic gnt0, gnt1, sel, busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  arb2_rr #(
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req0  (req0),
    .req1  (req1),
`ifdef ARB2_LOCK_EN
    .lock  (lock_i),
`endif
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .sel   (sel),
    .busy  (busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who owns the mux, for how many cycles, who won last.
  int owner = -1;
  int held  = 0;
  int last  = 1;
  int sel_m = 0;

  always @(posedge clk or negedge rst_n) begin
    int nxt;
    bit r [2];
    bit lk;
    if (!rst_n) begin
      owner = -1;
      held  = 0;
      last  = 1;
      sel_m = 0;
    end else begin
      r[0] = req0;
      r[1] = req1;
`ifdef ARB2_LOCK_EN
      lk = lock_i;
`else
      lk = 1'b0;
`endif
      nxt = owner;
      if (owner < 0) begin
        if (r[0] && r[1]) nxt = 1 - last;
        else if (r[0])    nxt = 0;
        else if (r[1])    nxt = 1;
      end else if (!r[owner]) begin
        nxt = r[1-owner] ? 1 - owner : -1;
      end else if (r[1-owner] && held >= int'(MAX_HOLD) && !lk) begin
        nxt = 1 - owner;
      end
      if (nxt >= 0 && nxt != owner) begin
        held  = 1;
        last  = nxt;
        sel_m = nxt;
      end else if (nxt >= 0) begin
        held++;
      end
      owner = nxt;
    end
  end

  // Every-cycle comparison against the model.
  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      chk("m_gnt0", int'(gnt0), int'(owner == 0));
      chk("m_gnt1", int'(gnt1), int'(owner == 1));
      chk("m_sel",  int'(sel),  sel_m);
      chk("m_busy", int'(busy), int'(owner >= 0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    lock_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    logic [1:0] vec [12];

    // Reset state
    #1;
    chk("rst_gnt0", int'(gnt0), 0);
    chk("rst_gnt1", int'(gnt1), 0);
    chk("rst_sel",  int'(sel),  0);
    chk("rst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request: one-cycle latency
    @(negedge clk); req0 = 1'b1;
    tick();
    chk("s1_gnt0", int'(gnt0), 1);
    chk("s1_sel",  int'(sel),  0);
    chk("s1_gnt1", int'(gnt1), 0);
    @(negedge clk); req0 = 1'b0;
    tick();
    chk("s1_idle_busy", int'(busy), 0);
    // Pointer: channel 0 won last, so a tie now goes to channel 1
    @(negedge clk); req0 = 1'b1; req1 = 1'b1;
    tick();
    chk("rr_tie_gnt1", int'(gnt1), 1);
    chk("rr_tie_sel",  int'(sel),  1);
    @(negedge clk); req0 = 1'b0; req1 = 1'b0;
    tick();

    // Tie after reset: channel 0 first, then hand-over without a bubble
    do_reset();
    @(negedge clk); req0 = 1'b1; req1 = 1'b1;
    tick();
    chk("s2_first_gnt0", int'(gnt0), 1);
    tick();
    tick();
    chk("s2_still_gnt0", int'(gnt0), 1);
    @(negedge clk); req0 = 1'b0;
    tick();
    chk("s2_gnt1", int'(gnt1), 1);
    chk("s2_gnt0", int'(gnt0), 0);
    chk("s2_sel",  int'(sel),  1);
    @(negedge clk); req1 = 1'b0;
    tick();
    chk("s2_idle_sel_kept", int'(sel),  1);
    chk("s2_idle_busy",     int'(busy), 0);

    // Preemption after MAX_HOLD cycles
    do_reset();
    @(negedge clk); req0 = 1'b1;
    tick();
    @(negedge clk); req1 = 1'b1;
    n = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!gnt0) break;
      n++;
    end
    chk("s3_gnt0_cycles", n, 4);
    chk("s3_gnt1", int'(gnt1), 1);
    chk("s3_sel",  int'(sel),  1);
    tick(); tick(); tick();
    tick();
    chk("s3_back_gnt0", int'(gnt0), 1);
    @(negedge clk); req0 = 1'b0; req1 = 1'b0;
    tick();

    // Uncontested hold, then saturated counter preempts at once
    do_reset();
    @(negedge clk); req1 = 1'b1;
    tick();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (gnt1) n++;
      tick();
    end
    chk("s4_gnt1_cycles", n, 20);
    @(negedge clk); req0 = 1'b1;
    tick();
    chk("s4_sat_preempt", int'(gnt0), 1);
    @(negedge clk); req0 = 1'b0;
    tick();
    chk("s4_back_gnt1", int'(gnt1), 1);

    // Asynchronous reset mid-GNT1
    #1;
    rst_n = 1'b0;
    #1;
    chk("s5_gnt1", int'(gnt1), 0);
    chk("s5_sel",  int'(sel),  0);
    chk("s5_busy", int'(busy), 0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk("s5_restart_gnt1", int'(gnt1), 1);
    @(negedge clk); req1 = 1'b0;
    tick();

`ifdef ARB2_LOCK_EN
    // Lock suppresses preemption; release lets it happen on the next edge
    do_reset();
    @(negedge clk); lock_i = 1'b1; req0 = 1'b1; req1 = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (gnt0) n++;
    end
    chk("s6_locked_gnt0", n, 8);
    @(negedge clk); lock_i = 1'b0;
    tick();
    chk("s6_unlock_gnt1", int'(gnt1), 1);
    @(negedge clk); req0 = 1'b0; req1 = 1'b0;
    tick();
`endif

    // Directed mix, checked by the model every cycle
    do_reset();
    vec = '{2'b11, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b11, 2'b11,
            2'b11, 2'b11, 2'b10, 2'b00};
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      req1 = vec[i][1];
      req0 = vec[i][0];
    end
    @(negedge clk); req0 = 1'b0; req1 = 1'b0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arb2_rr.md
ARB2_RR -- requirements
Module: arb2_rr

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 8, meaning the maximum number of consecutive grant cycles before a contested grant is revoked (legal range 2..255).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port req0  input  1  request from channel 0, the source on mux input a.
REQ-005 SHALL have port req1  input  1  request from channel 1, the source on mux input b.
REQ-006 SHALL have port gnt0  output  1  grant to channel 0, registered.
REQ-007 SHALL have port gnt1  output  1  grant to channel 1, registered.
REQ-008 SHALL have port sel  output  1  registered select for the downstream 2:1 mux (0 = a/channel 0, 1 = b/channel 1).
REQ-009 SHALL have port busy  output  1  high whenever either grant is high.
REQ-010 SHALL have port lock  input  1  present only when ARB2_LOCK_EN is defined; inhibits preemption.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, GNT0, GNT1.
REQ-012 SHALL hold gnt0 = 1 only in GNT0 and gnt1 = 1 only in GNT1; the grants are never both high.
REQ-013 SHALL set sel = 0 in GNT0 and sel = 1 in GNT1; in IDLE, sel SHALL keep its last value.
REQ-014 IDLE -> GNTx SHALL occur on the edge after reqx is sampled high, giving 1-cycle request-to-grant latency.
REQ-015 When in IDLE with req0 and req1 both high, SHALL grant the channel that did not win last (round-robin pointer); after reset, channel 0 SHALL be preferred.
REQ-016 GNTx, with reqx low and the other request high, SHALL go directly to the other grant state with no IDLE bubble.
REQ-017 GNTx, with reqx low and the other request low, SHALL go to IDLE.
REQ-018 SHALL keep a hold counter that clears on entry to any grant state and increments each cycle in a grant state, saturating at MAX_HOLD-1.
REQ-019 GNTx, with reqx high, the other request high and the counter at MAX_HOLD-1, SHALL switch to the other grant state (preemption).
REQ-020 GNTx, with reqx high and the other request low, SHALL stay in GNTx indefinitely; the counter SHALL stay saturated.
REQ-021 SHALL update the round-robin pointer to the granted channel on every grant-state entry.
REQ-022 Requests SHALL be level-sensitive; a request withdrawn before it is granted SHALL be dropped silently.

Reset
REQ-023 While rst_n is low, SHALL force, without waiting for clk: state = IDLE, gnt0 = 0, gnt1 = 0, sel = 0, busy = 0, counter = 0, pointer = channel 1 last (channel 0 preferred next).
REQ-024 Reset asserted during a grant SHALL drop the grant immediately; after release, arbitration SHALL restart from IDLE on the first clk edge.

Configuration
REQ-025 With ARB2_LOCK_EN defined, SHALL add the lock port; while lock is high, the preemption of REQ-019 SHALL be suppressed, and voluntary release (REQ-016, REQ-017) SHALL still apply.
REQ-026 Without ARB2_LOCK_EN, SHALL have no lock port, and preemption SHALL always be enabled.

Structure
REQ-027 SHALL take its FSM state encodings (IDLE = 2'b00, GNT0 = 2'b01, GNT1 = 2'b10) and the channel index constants from the shared package arb2_pkg.
REQ-028 SHALL place the saturating hold counter in the sub-module arb2_hold_cnt (inputs clk, rst_n, clr, en; output at_max).
REQ-029 The sel output SHALL connect directly to the select input of the team's gate-level 2:1 mux without further logic.

Verification
REQ-030 Scenario: reset, then req0 = 1 at cycle 2 -> gnt0 = 1 and sel = 0 at cycle 3; gnt1 = 0 throughout.
REQ-031 Scenario: req0 and req1 rise together from IDLE after reset -> gnt0 first; both drop req0 after 3 cycles -> gnt1 on the next edge with no IDLE cycle, and sel = 1.
REQ-032 Scenario: MAX_HOLD = 4, req0 held high, req1 raised 1 cycle after gnt0 -> gnt0 high exactly 4 cycles, then gnt1 high and sel = 1.
REQ-033 Scenario: req1 held alone for 20 cycles -> gnt1 stays high for all 20 cycles with no preemption.
REQ-034 Scenario: rst_n pulled low mid-GNT1 without a clk edge -> gnt1 = 0, sel = 0 and busy = 0 immediately.
REQ-035 Scenario (ARB2_LOCK_EN): MAX_HOLD = 4, lock = 1, both requests held -> gnt0 stays high past 4 cycles; lock dropped -> gnt1 on the next edge.
